// File: rtl/scan_sseg_multi_disp.sv
// -----------------------------------------------------------------------------
// scan_sseg_multi_disp
//
// Time-multiplexed seven-segment driver for NUM_DIGITS digits. A full frame of
// hex digits, decimal points, digit enables and the leading-zero flag is held
// in shadow registers that only change at a frame wrap, so one scan of the
// display never mixes old and new data. Each digit slot lasts SCAN_DIV clocks;
// the first BLANK_CYC clocks of a slot keep every anode off to avoid ghosting.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   hex_in     in   digit i value at [4i+3:4i]; digit 0 is rightmost
//   dp_in      in   decimal point request per digit (1 = lit)
//   en_in      in   digit enable (0 = dark, slot still consumed)
//   lz_blank   in   leading-zero suppression enable, captured with the frame
//   load       in   one-cycle strobe requesting a capture at the next wrap
//   an         out  digit select (registered), polarity by AN_ACTIVE_LOW
//   sseg       out  segments {g,f,e,d,c,b,a} (registered), by SEG_ACTIVE_LOW
//   dp_out     out  decimal point (registered), by SEG_ACTIVE_LOW
//   frame_tick out  one-cycle pulse at each frame start
// -----------------------------------------------------------------------------
module scan_sseg_multi_disp #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   hex_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     en_in,
  input  logic                      lz_blank,
  input  logic                      load,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                sseg,
  output logic                      dp_out,
  output logic                      frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  // Idle (unlit / unselected) pin levels for the chosen polarities.
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;

  // Hex to seven-segment, active-low form {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode_hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] sh_hex_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_en_q;
  logic                    sh_lz_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q;

  logic                    slot_end_s;
  logic                    wrap_s;
  logic                    capture_s;
  logic [NUM_DIGITS-1:0]   visible_s;
  logic [NUM_DIGITS-1:0]   onehot_s;

  // Slot counter, digit index and pending-load bookkeeping.
  always_comb begin
    slot_end_s = (cnt_q == CNT_MAX);
    wrap_s     = slot_end_s && (idx_q == IDX_MAX);
    capture_s  = wrap_s && (pend_q || load);

    if (slot_end_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (wrap_s) begin
      idx_d = {IDX_W{1'b0}};
    end else if (slot_end_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end

    // Every wrap consumes the request; loads between wraps merge into one.
    if (wrap_s) begin
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Visibility: enable gated by leading-zero suppression. Scanning from the
  // most significant digit down, zero_run stays set while every enabled digit
  // seen so far is 0 with no dp; disabled digits do not break the run.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    visible_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (sh_en_q[i] && ((sh_hex_q[4*i +: 4] != 4'h0) || sh_dp_q[i])) begin
        zero_run = 1'b0;
      end else begin
        zero_run = zero_run;
      end
      visible_s[i] = sh_en_q[i] && !(sh_lz_q && zero_run && (i != 0));
    end
  end

  // Next pin values for the current (cnt, idx), polarity applied.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (idx_q == IDX_W'(i));
    end
    if ((cnt_q < BLANK_END) || !visible_s[idx_q]) begin
      an_d   = AN_OFF;
      sseg_d = SEG_OFF;
      dp_d   = DP_OFF;
    end else begin
      // XOR with the idle level flips the selected bit to its active level.
      an_d   = AN_OFF ^ onehot_s;
      sseg_d = decode_hex(sh_hex_q[{idx_q, 2'b00} +: 4]) ^ {7{~SEG_ACTIVE_LOW}};
      dp_d   = sh_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= {CNT_W{1'b0}};
      idx_q  <= {IDX_W{1'b0}};
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
    end
  end

  // Shadow frame registers; inputs are sampled at the wrap, not at the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_hex_q <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_q  <= {NUM_DIGITS{1'b0}};
      sh_en_q  <= {NUM_DIGITS{1'b0}};
      sh_lz_q  <= 1'b0;
    end else if (capture_s) begin
      sh_hex_q <= hex_in;
      sh_dp_q  <= dp_in;
      sh_en_q  <= en_in;
      sh_lz_q  <= lz_blank;
    end else begin
      sh_hex_q <= sh_hex_q;
      sh_dp_q  <= sh_dp_q;
      sh_en_q  <= sh_en_q;
      sh_lz_q  <= sh_lz_q;
    end
  end

  // Registered display pins and frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= AN_OFF;
      sseg_q <= SEG_OFF;
      dp_q   <= DP_OFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
      tick_q <= wrap_s;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_scan_sseg_multi_disp.sv
// -----------------------------------------------------------------------------
// tb_scan_sseg_multi_disp
//
// Directed bench: two instances (4 digits, 8 clocks per slot, 2 blank clocks),
// one with active-low pins and one with active-high pins, driven by the same
// inputs. Each frame is checked slot by slot against hand-computed values for
// the active-low instance; the active-high expectation is its inverse.
// -----------------------------------------------------------------------------
module tb_scan_sseg_multi_disp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        lz_blank;
  logic        load;

  logic [3:0]  an_lo, an_hi;
  logic [6:0]  sseg_lo, sseg_hi;
  logic        dp_lo, dp_hi;
  logic        tick_lo, tick_hi;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  scan_sseg_multi_disp #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .en_in(en_in),
    .lz_blank(lz_blank), .load(load), .an(an_lo), .sseg(sseg_lo),
    .dp_out(dp_lo), .frame_tick(tick_lo)
  );

  scan_sseg_multi_disp #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .en_in(en_in),
    .lz_blank(lz_blank), .load(load), .an(an_hi), .sseg(sseg_hi),
    .dp_out(dp_hi), .frame_tick(tick_hi)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a frame_tick on the active-low instance.
  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tick_lo) seen = 1'b1;
    end
    check_vec(tag, {31'd0, seen}, 32'd1);
  endtask

  // Called at the negedge where frame_tick is high; consumes one 32-clock
  // frame and ends on the next frame_tick. ean/eseg/edp are the active-low
  // expectations per slot ([k] = slot k). load is pulsed at load_step (0=none).
  task automatic check_frame(input string tag, input logic [3:0][3:0] ean,
                             input logic [3:0][6:0] eseg, input logic [3:0] edp,
                             input int load_step);
    for (int n = 1; n <= 32; n++) begin
      int k;
      int ph;
      @(negedge clk);
      if (load_step != 0) load = (n == load_step);
      k  = (n - 1) / 8;
      ph = (n - 1) % 8;
      if (ph == 0) begin
        check_vec($sformatf("%s_blank_lo_s%0d", tag, k),
                  {20'd0, an_lo, sseg_lo, dp_lo}, {20'd0, 4'hF, 7'h7F, 1'b1});
        check_vec($sformatf("%s_blank_hi_s%0d", tag, k),
                  {20'd0, an_hi, sseg_hi, dp_hi}, {20'd0, 4'h0, 7'h00, 1'b0});
      end
      if (ph == 4) begin
        check_vec($sformatf("%s_lo_s%0d", tag, k),
                  {20'd0, an_lo, sseg_lo, dp_lo}, {20'd0, ean[k], eseg[k], edp[k]});
        check_vec($sformatf("%s_hi_s%0d", tag, k),
                  {20'd0, an_hi, sseg_hi, dp_hi}, {20'd0, ~ean[k], ~eseg[k], ~edp[k]});
      end
      if (n == 16) check_vec({tag, "_tick_mid"}, {30'd0, tick_lo, tick_hi}, 32'd0);
      if (n == 32) check_vec({tag, "_tick_end"}, {30'd0, tick_lo, tick_hi}, 32'd3);
    end
    load = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    hex_in   = 16'h0000;
    dp_in    = 4'h0;
    en_in    = 4'h0;
    lz_blank = 1'b0;
    load     = 1'b0;

    repeat (3) @(negedge clk);
    check_vec("rst_lo", {19'd0, an_lo, sseg_lo, dp_lo, tick_lo}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    check_vec("rst_hi", {19'd0, an_hi, sseg_hi, dp_hi, tick_hi}, {19'd0, 4'h0, 7'h00, 1'b0, 1'b0});
    reset = 1'b0;

    // Inputs present but no load yet: display stays dark; load mid-frame.
    hex_in = 16'h3210;
    en_in  = 4'hF;
    wait_tick("tick_first");
    check_frame("dark0", {4'hF, 4'hF, 4'hF, 4'hF}, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 10);

    // Scan order 0..3 showing 3210; request 1234 at idx=1 mid-frame.
    hex_in = 16'h1234;
    check_frame("scan3210", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF, 10);

    // Input changes after the wrap without load must never appear.
    hex_in = 16'h9999;
    check_frame("coh1234a", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0);

    hex_in   = 16'h0050;
    lz_blank = 1'b1;
    check_frame("coh1234b", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 10);

    // Leading zeros: digits 3,2 dark.
    dp_in = 4'b0100;
    check_frame("lz0050", {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 10);

    // dp on digit 2 keeps it visible; digit 3 still suppressed.
    dp_in  = 4'b0000;
    hex_in = 16'h0000;
    check_frame("lzdp2", {4'hF, 4'hB, 4'hD, 4'hE}, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011, 10);

    // All zero: only digit 0 lit.
    hex_in   = 16'h8888;
    en_in    = 4'b0101;
    lz_blank = 1'b0;
    check_frame("lzall0", {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 10);

    // Enables 0101 showing 8; load pulsed exactly in the wrap cycle.
    hex_in = 16'hABCD;
    en_in  = 4'hF;
    check_frame("en0101", {4'hF, 4'hB, 4'hF, 4'hE}, {7'h7F, 7'h00, 7'h7F, 7'h00}, 4'hF, 31);

    // Shadow took ABCD at the wrap; no request may remain pending.
    hex_in = 16'h0000;
    check_frame("wrapld_a", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 0);
    check_frame("wrapld_b", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 0);

    // Reset in the middle of slot 0 while digit 0 is lit.
    repeat (5) @(negedge clk);
    check_vec("prerst_lo", {20'd0, an_lo, sseg_lo, dp_lo}, {20'd0, 4'hE, 7'h21, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check_vec("midrst_lo", {19'd0, an_lo, sseg_lo, dp_lo, tick_lo}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    check_vec("midrst_hi", {19'd0, an_hi, sseg_hi, dp_hi, tick_hi}, {19'd0, 4'h0, 7'h00, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    hex_in = 16'h8888;
    wait_tick("tick_after_rst");
    check_frame("dark_rst", {4'hF, 4'hF, 4'hF, 4'hF}, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
